// File: rtl/step_dwell_pkg.sv
// Shared definitions for the dwell output stage: state encoding, default
// geometry and the {n, d} field-split macros also used by the sequencer.
`ifndef STEP_DWELL_FIELDS_SVH
`define STEP_DWELL_FIELDS_SVH
// Dwell-count field (upper bits) of a command word.
`define DW_FIELD_N(w, nw, ddw) w[(nw)+(ddw)-1:(ddw)]
// Output pattern field (lower bits) of a command word.
`define DW_FIELD_D(w, ddw) w[(ddw)-1:0]
`endif

package step_dwell_pkg;

  // Default geometry, matching the sequencer's data_o layout.
  localparam int DW_NW    = 5;
  localparam int DW_DDW   = 4;
  localparam int DW_PRESC = 256;
  localparam int DW_DT    = 2;

  typedef enum logic [1:0] {
    DW_IDLE  = 2'd0,
    DW_DEAD  = 2'd1,
    DW_DWELL = 2'd2
  } dw_state_e;

endpackage

// File: rtl/step_dwell_tick_prescaler.sv
// Modulo-presc counter with synchronous clear; tick_o is high for the one
// cycle in which an enabled count sits at presc-1 (the wrap cycle).
module tick_prescaler #(
  parameter int presc = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = (presc > 1) ? $clog2(presc) : 1;
  localparam logic [PW-1:0] LAST = PW'(presc - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_dwell.sv
// Output stage behind the sequencer: holds each pattern d for n*presc
// clocks, inserts an all-off gap of dt clocks between two different
// energised patterns, and backpressures through valid/ready.
module step_dwell
  import step_dwell_pkg::*;
#(
  parameter int nw    = DW_NW,
  parameter int ddw   = DW_DDW,
  parameter int presc = DW_PRESC,
  parameter int dt    = DW_DT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [nw+ddw-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [ddw-1:0]    data_o,
  output logic              idle_o
);

  localparam int CW = (dt > 0) ? $clog2(dt + 1) : 1;
  localparam logic [CW-1:0] DEAD_LAST = (dt > 0) ? CW'(dt - 1) : '0;

  dw_state_e         state_q, state_d;
  logic [ddw-1:0]    data_q, data_d;
  logic [nw+ddw-1:0] word_q, word_d;
  logic [nw-1:0]     dwell_q, dwell_d;
  logic [CW-1:0]     dead_q, dead_d;

  logic              pre_clr, pre_en, pre_tick;
  logic              last_dwell, xfer, wants_dead;
  logic [nw-1:0]     n_in;
  logic [ddw-1:0]    d_in;

  // The prescaler only runs while a pattern is being dwelt on.
  assign pre_en = (state_q == DW_DWELL);

  tick_prescaler #(.presc(presc)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (pre_clr),
    .en_i  (pre_en),
    .tick_o(pre_tick)
  );

  assign n_in = `DW_FIELD_N(data_i, nw, ddw);
  assign d_in = `DW_FIELD_D(data_i, ddw);

  // Final cycle of a non-zero dwell: accepting here gives back-to-back words.
  assign last_dwell = (state_q == DW_DWELL) && (dwell_q == nw'(1)) && pre_tick;
  assign ready_o    = (state_q == DW_IDLE) || last_dwell;
  assign xfer       = valid_i && ready_o;
  assign idle_o     = (state_q == DW_IDLE);
  assign data_o     = data_q;

  // Gap only when switching from one energised pattern to another.
  assign wants_dead = (dt > 0) && (data_q != '0) && (d_in != data_q) && (d_in != '0);

  // Next-state and datapath updates; a transfer overrides the dwell exit.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    word_d  = word_q;
    dwell_d = dwell_q;
    dead_d  = dead_q;
    pre_clr = 1'b0;

    case (state_q)
      DW_DEAD: begin
        if (dead_q == DEAD_LAST) begin
          data_d  = `DW_FIELD_D(word_q, ddw);
          dwell_d = `DW_FIELD_N(word_q, nw, ddw);
          pre_clr = 1'b1;
          state_d = DW_DWELL;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      DW_DWELL: begin
        // n=0 occupies exactly one cycle with the pattern applied.
        if (dwell_q == '0) begin
          state_d = DW_IDLE;
        end else if (pre_tick) begin
          dwell_d = dwell_q - 1'b1;
          if (dwell_q == nw'(1)) state_d = DW_IDLE;
        end
      end
      default: ;
    endcase

    if (xfer) begin
      word_d  = data_i;
      dead_d  = '0;
      pre_clr = 1'b1;
      if (wants_dead) begin
        data_d  = '0;
        state_d = DW_DEAD;
      end else begin
        data_d  = d_in;
        dwell_d = n_in;
        state_d = DW_DWELL;
      end
    end
  end

  // State and datapath registers; reset forces the outputs off at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DW_IDLE;
      data_q  <= '0;
      word_q  <= '0;
      dwell_q <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      word_q  <= word_d;
      dwell_q <= dwell_d;
      dead_q  <= dead_d;
    end
  end

endmodule

// File: tb/tb_step_dwell.sv
// Scoreboard bench for step_dwell (presc=4, dt=2, nw=5, ddw=4): every accepted
// word pushes its expected per-cycle output trace; each cycle pops and checks.
module tb_step_dwell;

  localparam int PRESC = 4;
  localparam int DT    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [3:0] data_o;
  logic       idle_o;

  typedef struct packed {
    logic [3:0] dat;
    logic       rdy;
    logic       idl;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] pend_q[$];
  logic [3:0] held = '0;
  int n_cmp = 0, n_err = 0, dut_busy = 0, dut_xfer = 0;

  step_dwell #(.nw(5), .ddw(4), .presc(PRESC), .dt(DT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .idle_o (idle_o)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mkw(input int n, input logic [3:0] d);
    return {5'(n), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected trace for one accepted word, given the output at the transfer.
  task automatic push_word(input logic [8:0] wd, input logic [3:0] prev);
    logic [4:0] n;
    logic [3:0] d;
    int len;
    n = wd[8:4];
    d = wd[3:0];
    if (d != 4'h0 && prev != 4'h0 && d != prev)
      repeat (DT) exp_q.push_back('{dat: 4'h0, rdy: 1'b0, idl: 1'b0});
    len = (n == 0) ? 1 : int'(n) * PRESC;
    for (int i = 0; i < len; i++)
      exp_q.push_back('{dat: d, rdy: (n != 0 && i == len - 1), idl: 1'b0});
  endtask

  // One cycle: check outputs at negedge, then drive inputs for the next edge.
  task automatic step(input bit gaps);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '{dat: held, rdy: 1'b1, idl: 1'b1};
    chk("data_o", 32'(data_o), 32'(e.dat));
    chk("ready_o", 32'(ready_o), 32'(e.rdy));
    chk("idle_o", 32'(idle_o), 32'(e.idl));
    held = e.dat;
    if (!idle_o) dut_busy++;
    if (pend_q.size() > 0 && !(gaps && $urandom_range(3) == 0)) begin
      valid_i = 1'b1;
      data_i  = pend_q[0];
    end else begin
      valid_i = 1'b0;
      data_i  = 9'($urandom);
    end
    if (valid_i && ready_o) dut_xfer++;
    if (valid_i && e.rdy) push_word(pend_q.pop_front(), e.dat);
  endtask

  task automatic run(input int max_cyc, input bit gaps);
    int k = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && k < max_cyc) begin
      step(gaps);
      k++;
    end
    if (k >= max_cyc) chk("run_timeout", 32'(k), 32'(0));
    repeat (2) step(gaps);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_data_o", 32'(data_o), 32'(0));
      chk("rst_ready_o", 32'(ready_o), 32'(1));
      chk("rst_idle_o", 32'(idle_o), 32'(1));
    end
    rst_n = 1'b1;
    exp_q.delete();
    pend_q.delete();
    held = '0;
  endtask

  initial begin
    logic [3:0] pats [5];
    int exp_busy;
    logic [3:0] prv;
    pats = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b0000};

    // 1: single word from reset
    do_reset();
    pend_q.push_back(mkw(2, 4'b1001));
    run(200, 1'b0);

    // 2: back-to-back different patterns, dead time between
    do_reset();
    pend_q.push_back(mkw(2, 4'b1001));
    pend_q.push_back(mkw(2, 4'b1100));
    run(200, 1'b0);

    // 3: same pattern repeated, no dead time
    do_reset();
    pend_q.push_back(mkw(1, 4'b0110));
    pend_q.push_back(mkw(1, 4'b0110));
    run(200, 1'b0);

    // 4: zero dwell then all-off pattern
    do_reset();
    pend_q.push_back(mkw(0, 4'b0011));
    pend_q.push_back(mkw(3, 4'b0000));
    run(200, 1'b0);

    // 5: asynchronous reset in the middle of a dwell
    do_reset();
    pend_q.push_back(mkw(4, 4'b1001));
    repeat (6) step(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data_o", 32'(data_o), 32'(0));
    chk("async_rst_ready_o", 32'(ready_o), 32'(1));
    chk("async_rst_idle_o", 32'(idle_o), 32'(1));
    valid_i = 1'b0;
    exp_q.delete();
    pend_q.delete();
    held = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pend_q.push_back(mkw(2, 4'b1100));
    run(200, 1'b0);

    // 6: valid held high over a queue of alternating words
    do_reset();
    pend_q.push_back(mkw(2, 4'b1001));
    pend_q.push_back(mkw(1, 4'b1100));
    pend_q.push_back(mkw(3, 4'b0110));
    pend_q.push_back(mkw(2, 4'b0011));
    pend_q.push_back(mkw(1, 4'b1001));
    exp_busy = (2 + 1 + 3 + 2 + 1) * PRESC + 4 * DT;
    dut_busy = 0;
    dut_xfer = 0;
    run(400, 1'b0);
    chk("bp_busy_cycles", 32'(dut_busy), 32'(exp_busy));
    chk("bp_transfers", 32'(dut_xfer), 32'(5));

    // 7: random words with random valid gaps
    do_reset();
    for (int i = 0; i < 25; i++)
      pend_q.push_back(mkw($urandom_range(3), pats[$urandom_range(4)]));
    prv = '0;
    dut_xfer = 0;
    run(3000, 1'b1);
    chk("rnd_transfers", 32'(dut_xfer), 32'(25));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_dwell.md
Name: step_dwell

Overview:
- Downstream output stage of `sequencer`. Consumes each `{nnnnn, dddd}` word the sequencer emits.
- Drives the `dddd` pattern on output pins for `nnnnn × presc` clock cycles. Typical load: stepper phases 1001/1100/0110/0011.
- Inserts an all-off dead time between two different energised patterns.
- Backpressures the sequencer through a valid/ready handshake.

Parameters:
- nw, 5, width of the dwell-count field (upper bits of data_i).
- ddw, 4, width of the output pattern field (lower bits of data_i).
- presc, 256, clocks per dwell unit (≥1).
- dt, 2, dead-time length in clocks (0 disables dead time).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- data_i  in  nw+ddw  command word {n[nw-1:0], d[ddw-1:0]}.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block accepts data_i this cycle.
- data_o  out  ddw  registered output pattern.
- idle_o  out  1  high in IDLE (no dwell or dead time in progress).

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, data_o=0, prescaler=0, dwell counter=0, dead counter=0, latched word=0.
  - While rst_n=0, ready_o and idle_o read 1, but no transfer takes place.
- Transfer: occurs at a posedge where valid_i && ready_o.
  - data_i is latched at that edge.
  - data_i may change freely when no transfer occurs.
- ready_o (combinational): `(state==IDLE) || (state==DWELL && last_dwell_cycle)`. This allows back-to-back words with no bubble.
- States:
  - IDLE: data_o holds its last value. On transfer, go to DEAD or DWELL.
  - DEAD: data_o=0 for exactly dt cycles, then load d and enter DWELL.
  - DWELL: data_o=d for exactly n×presc cycles.
    - Prescaler counts 0..presc-1.
    - Dwell counter decrements on each prescaler wrap.
    - The last cycle is dwell=1 with prescaler=presc-1.
    - On exit: transfer pending goes to DEAD/DWELL for the new word; otherwise go to IDLE.
- Dead-time rule: DEAD is entered only if all of the following hold; otherwise go straight to DWELL with data_o=d from the cycle after the transfer:
  - dt>0,
  - current data_o≠0,
  - d≠current data_o,
  - d≠0.
- n=0: data_o=d is applied (after dead time if the rule triggers), then IDLE the next cycle. The block is occupied for exactly one cycle after DEAD, and the output is held.
- Latency: data_o changes 1 cycle after the transfer edge (no DEAD) or dt+1 cycles after it (DEAD).
- Widths:
  - Dwell counter: nw bits.
  - Prescaler: `$clog2(presc)` bits, minimum 1.
  - Dead counter: `$clog2(dt+1)` bits.
  - No overflow is possible; n=2^nw-1 is the maximum.
- Reset mid-DWELL or mid-DEAD: immediate return to reset values. data_o=0 asynchronously; the pending word is discarded.
- valid_i held high across DEAD: no transfer happens until ready_o rises.

Decomposition:
- Shared package/header:
  - state encoding constants `DW_IDLE`, `DW_DEAD`, `DW_DWELL`;
  - field-split macros for {n, d} shared with `sequencer` (same nw/ddw layout as the sequencer's data_o).
- One natural sub-module: `tick_prescaler`. It is a presc-modulo counter with a synchronous clear and a one-cycle tick output, reusable elsewhere.

Test Plan (presc=4, dt=2, nw=5, ddw=4):
1. Reset, then word {2,1001} with valid at edge 0 -> data_o=1001 on cycles 1–8; ready_o low cycles 1–7 and high cycle 8; idle_o high from cycle 9.
2. Back-to-back: {2,1001} then {2,1100} offered at cycle 8 -> accepted at edge 8; data_o=0000 on cycles 9–10; data_o=1100 on cycles 11–18; no IDLE cycle between the two words.
3. Same pattern repeated: {1,0110} followed by {1,0110} -> no dead time; data_o=0110 continuous for 8 cycles.
4. Zero-dwell and off pattern:
   - {0,0011} from reset -> data_o=0011 at cycle 1, IDLE at cycle 2, output held;
   - then {3,0000} -> no DEAD; data_o=0000 for 12 cycles.
5. Reset mid-operation: rst_n low at cycle 5 of a {4,1001} dwell -> data_o=0 immediately with no clock edge needed; after release, idle_o=1 and ready_o=1; the next word behaves as from reset.
6. Backpressure: valid_i held high with alternating words while sequencer-side words are queued -> every word transferred exactly once; dwell lengths are exact multiples of presc; the total cycle count matches the sum of n×4 plus 2 per pattern change.
